elevator_sched: RTL and testbench
=================================

ELEVATOR_SCHED -- requirements
Module: elevator_sched

Interface
REQ-001 SHALL provide parameter n, default 6, meaning number of floors (width of all floor vectors).
REQ-002 SHALL provide parameter MOVE_CYC, default 4, meaning clock cycles per one-floor travel step (legal range 1 to 255).
REQ-003 SHALL provide parameter DOOR_CYC, default 8, meaning clock cycles the door stays open (legal range 1 to 255).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  n  floor call requests, one bit per floor (bit 0 = floor 1), any number of bits, sampled every cycle.
REQ-007 cur_floor  input  n  one-hot current floor from the floor-position register, updated on the same edge that samples count_up/count_down.
REQ-008 count_up  output  1  single-cycle step-up command to the floor-position register.
REQ-009 count_down  output  1  single-cycle step-down command to the floor-position register.
REQ-010 door_open  output  1  high while the door is open at cur_floor.
REQ-011 pending  output  n  registered outstanding calls.
REQ-012 dir_up  output  1  current or last travel direction, 1 = up.
REQ-013 fault  output  1  high in any cycle where cur_floor is not one-hot.

Function
REQ-014 The pending register SHALL update as pending <= (pending | req) & ~clr, where clr = cur_floor in any cycle with state DOOR, else 0.
REQ-015 A req bit SHALL first be visible on pending one cycle after it is sampled.
REQ-016 FSM states SHALL be IDLE, UP, DOWN, CHECK, DOOR.
REQ-017 IDLE: if pending & cur_floor nonzero -> DOOR; else if any pending bit above cur_floor -> UP with dir_up=1; else if any below -> DOWN with dir_up=0; else stay.
REQ-018 In IDLE, when calls exist both above and below, the current dir_up direction SHALL be chosen.
REQ-019 UP/DOWN SHALL last exactly MOVE_CYC cycles, counted by an 8-bit step timer cleared on entry; count_up (UP) or count_down (DOWN) SHALL be high only in the final cycle; next state CHECK.
REQ-020 CHECK (one cycle, cur_floor already updated): if pending & cur_floor nonzero -> DOOR; else if pending remains in dir_up direction -> continue the same direction; else if pending remains in the opposite direction -> reverse dir_up and move; else -> IDLE.
REQ-021 DOOR SHALL last exactly DOOR_CYC cycles with door_open=1 and then go to IDLE; a req at cur_floor during DOOR SHALL be absorbed and SHALL NOT extend the door time.
REQ-022 count_up and count_down SHALL never be high in the same cycle, and neither SHALL be high while door_open=1.
REQ-023 count_up SHALL never be issued when cur_floor is the top floor, and count_down SHALL never be issued when cur_floor is floor 1.
REQ-024 If fault=1, the block SHALL issue no count pulse, hold its state and timers, and still accept requests into pending.
REQ-025 All outputs SHALL be registered, except fault, which is combinational from cur_floor.

Reset
REQ-026 While reset=1, outputs SHALL assert immediately and asynchronously as: state IDLE, pending 0, count_up 0, count_down 0, door_open 0, dir_up 1, timers 0.
REQ-027 Assertion of reset mid-move or mid-door SHALL discard all pending calls; operation SHALL resume from IDLE on the first edge after reset deasserts.

Verification
REQ-028 Reset: assert reset mid-UP with count_up high -> count_up, door_open and pending go to 0 without waiting for a clock edge; dir_up=1.
REQ-029 Basic trip (n=6, MOVE_CYC=4, DOOR_CYC=8): cur_floor 000001, one-cycle req 001000 -> 3 count_up pulses spaced 5 cycles apart, then door_open high for 8 cycles at 001000, pending[3] cleared, then IDLE.
REQ-030 Same-floor call: idle at 000100, req 000100 -> door_open rises 2 cycles after req, no count pulses.
REQ-031 Intermediate stop: moving up from floor 1 toward floor 5, req floor 3 during the first step -> door opens at floor 3, then travel continues to floor 5.
REQ-032 Direction retention: at floor 3 going up to floor 5, req floor 1 arrives -> floor 5 served first, dir_up then goes to 0, floor 1 served, count_up never high at floor 6.
REQ-033 Fault: force cur_floor 000011 for 10 cycles while a call is pending -> fault=1, no count pulses; normal service resumes when cur_floor is restored.

Source files
------------

// File: rtl/elevator_sched.sv
// Single-car elevator scheduler: latches floor calls, sequences travel steps
// and door time, and keeps going in the current direction while calls remain.
module elevator_sched #(
  parameter int n        = 6,
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] req,
  input  logic [n-1:0] cur_floor,
  output logic         count_up,
  output logic         count_down,
  output logic         door_open,
  output logic [n-1:0] pending,
  output logic         dir_up,
  output logic         fault
);

  localparam logic [7:0] MOVE_LAST = 8'(MOVE_CYC - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYC - 1);

  typedef enum logic [2:0] {IDLE, UP, DOWN, CHECK, DOOR} state_t;

  state_t       state, state_d;
  logic [7:0]   tmr, tmr_d;
  logic         dir_d;
  logic         count_up_d, count_down_d, door_open_d;
  logic [n-1:0] pending_d;
  logic [n-1:0] below_mask, above_mask, clr;
  logic         hit, any_above, any_below;

  // Floor masks relative to the one-hot position; fault when it is not one-hot
  always_comb begin
    below_mask = cur_floor - n'(1);
    above_mask = ~(below_mask | cur_floor);
    fault      = (cur_floor == '0) || ((cur_floor & below_mask) != '0);
    hit        = (pending & cur_floor) != '0;
    any_above  = (pending & above_mask) != '0;
    any_below  = (pending & below_mask) != '0;
  end

  // Next state, timer, direction and registered-output values
  always_comb begin
    state_d = state;
    tmr_d   = tmr;
    dir_d   = dir_up;
    if (!fault) begin
      case (state)
        IDLE: begin
          if (hit) begin
            state_d = DOOR;
            tmr_d   = '0;
          end else if (any_above && (dir_up || !any_below)) begin
            state_d = UP;
            dir_d   = 1'b1;
            tmr_d   = '0;
          end else if (any_below) begin
            state_d = DOWN;
            dir_d   = 1'b0;
            tmr_d   = '0;
          end
        end
        UP, DOWN: begin
          if (tmr == MOVE_LAST) begin
            state_d = CHECK;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr + 8'd1;
          end
        end
        CHECK: begin
          tmr_d = '0;
          if (hit) begin
            state_d = DOOR;
          end else if (dir_up && any_above) begin
            state_d = UP;
          end else if (!dir_up && any_below) begin
            state_d = DOWN;
          end else if (any_below) begin
            state_d = DOWN;
            dir_d   = 1'b0;
          end else if (any_above) begin
            state_d = UP;
            dir_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        DOOR: begin
          if (tmr == DOOR_LAST) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    // Step pulse only in the last travel cycle, never past an end floor
    count_up_d   = (state_d == UP) && (tmr_d == MOVE_LAST) && !fault && !cur_floor[n-1];
    count_down_d = (state_d == DOWN) && (tmr_d == MOVE_LAST) && !fault && !cur_floor[0];
    door_open_d  = (state_d == DOOR);
    clr          = (state == DOOR) ? cur_floor : '0;
    pending_d    = (pending | req) & ~clr;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tmr        <= '0;
      pending    <= '0;
      count_up   <= 1'b0;
      count_down <= 1'b0;
      door_open  <= 1'b0;
      dir_up     <= 1'b1;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      pending    <= pending_d;
      count_up   <= count_up_d;
      count_down <= count_down_d;
      door_open  <= door_open_d;
      dir_up     <= dir_d;
    end
  end

endmodule

// File: tb/tb_elevator_sched.sv
// Bench for elevator_sched: event-level reference model feeds a scoreboard of
// expected step pulses and door open/close events; a monitor checks them.
module tb_elevator_sched;

  localparam int N  = 6;
  localparam int MC = 4;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] cur_floor;
  logic         count_up, count_down, door_open, dir_up, fault;
  logic [N-1:0] pending;

  int checks = 0;
  int failures = 0;

  elevator_sched #(.n(N), .MOVE_CYC(MC), .DOOR_CYC(DC)) dut (
    .clk(clk), .reset(reset), .req(req), .cur_floor(cur_floor),
    .count_up(count_up), .count_down(count_down), .door_open(door_open),
    .pending(pending), .dir_up(dir_up), .fault(fault)
  );

  always #5 clk = ~clk;

  // Floor-position register driven by the step pulses; fault forcing overrides it
  int   fl = 0;
  logic flt_force = 1'b0;
  logic [N-1:0] fl_oh;
  always_comb fl_oh = N'(1) << fl;
  assign cur_floor = flt_force ? N'(3) : fl_oh;
  always @(posedge clk) begin
    if (!flt_force) begin
      if (count_up && fl < N - 1) fl <= fl + 1;
      else if (count_down && fl > 0) fl <= fl - 1;
    end
  end

  // Expected events: 0 step up, 1 step down, 2 door opens, 3 door closes
  typedef struct {
    int           kind;
    int           floor;
    int           cyc;
    logic         dir;
    logic [N-1:0] pend;
  } ev_t;
  ev_t expq[$];

  // Reference model: modes are deciding, moving up/down, door open
  int           cyc = 0;
  int           m_floor = 0;
  int           m_mode = 0;
  int           m_left = 0;
  logic         m_dir = 1'b1;
  logic [N-1:0] m_pend = '0;

  function automatic int choose(input int f, input logic d, input logic [N-1:0] p);
    bit above = 0, below = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && i > f) above = 1;
      if (p[i] && i < f) below = 1;
    end
    if (p[f]) return 3;
    if (d && above) return 1;
    if (!d && below) return 2;
    if (above) return 1;
    if (below) return 2;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_mode = 0; m_left = 0; m_dir = 1'b1; m_pend = '0;
      expq.delete();
    end else begin
      logic [N-1:0] clr, np;
      int d;
      clr = (m_mode == 3) ? (N'(1) << m_floor) : '0;
      np  = (m_pend | req) & ~clr;
      if (!flt_force) begin
        case (m_mode)
          0: begin
            d = choose(m_floor, m_dir, m_pend);
            if (d == 3) begin
              m_mode = 3; m_left = DC;
              expq.push_back('{2, m_floor, cyc, m_dir, np});
            end else if (d != 0) begin
              m_mode = d; m_left = MC; m_dir = (d == 1);
            end
          end
          1, 2: begin
            m_left--;
            if (m_left == 0) begin
              m_floor += (m_mode == 1) ? 1 : -1;
              m_mode = 0;
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 0;
              expq.push_back('{3, m_floor, cyc, m_dir, np});
            end
          end
        endcase
        if ((m_mode == 1 || m_mode == 2) && m_left == 1)
          expq.push_back('{m_mode - 1, m_floor, cyc, m_dir, np});
      end
      m_pend = np;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic match(input int kind);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: kind=%0d floor=%0d cyc=%0d, none expected", kind, fl, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind || e.floor != fl || e.cyc != cyc || e.dir != dir_up || e.pend != pending) begin
      failures++;
      $display("FAIL event: got kind=%0d floor=%0d cyc=%0d dir=%0b pend=%b, expected kind=%0d floor=%0d cyc=%0d dir=%0b pend=%b",
               kind, fl, cyc, dir_up, pending, e.kind, e.floor, e.cyc, e.dir, e.pend);
    end
  endtask

  // Monitor: compare observed pulses/door edges against the scoreboard
  logic prev_door = 1'b0;
  initial forever begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_door = 1'b0;
    end else begin
      chk("fault", int'(fault), int'(flt_force));
      chk("safety", int'((count_up && count_down) || ((count_up || count_down) && door_open)
                         || (count_up && cur_floor[N-1]) || (count_down && cur_floor[0])), 0);
      if (count_up) match(0);
      if (count_down) match(1);
      if (door_open && !prev_door) match(2);
      if (!door_open && prev_door) match(3);
      prev_door = door_open;
    end
  end

  task automatic issue(input logic [N-1:0] bits);
    @(negedge clk);
    req = bits;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle();
    int n_cyc = 0;
    while (!(m_mode == 0 && m_pend == '0 && expq.size() == 0) && n_cyc < 600) begin
      @(negedge clk);
      n_cyc++;
    end
    chk("drain_timeout", int'(n_cyc >= 600), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic try_fault(input int len);
    int n_cyc = 0;
    @(negedge clk);
    while ((count_up || count_down || door_open) && n_cyc < 100) begin
      @(negedge clk);
      n_cyc++;
    end
    flt_force = 1'b1;
    repeat (len) @(negedge clk);
    flt_force = 1'b0;
  endtask

  // Stimulus: directed trips, fault episode, random calls, reset mid-move
  initial begin
    int fault_left;
    int n_cyc;
    logic [N-1:0] r;
    repeat (3) @(negedge clk);
    chk("rst_count_up", int'(count_up), 0);
    chk("rst_count_down", int'(count_down), 0);
    chk("rst_door_open", int'(door_open), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_dir_up", int'(dir_up), 1);
    reset = 1'b0;

    issue(6'b001000); wait_idle();                 // basic trip floor 1 -> 4
    chk("trip_floor", fl, 3);
    issue(6'b001000); wait_idle();                 // same-floor call
    issue(6'b000001); wait_idle();
    issue(6'b010000); repeat (2) @(negedge clk);   // intermediate stop at 3
    issue(6'b000100); wait_idle();
    chk("stop_floor", fl, 4);
    issue(6'b000100); wait_idle();                 // direction retention
    issue(6'b010000); repeat (3) @(negedge clk);
    issue(6'b000001); wait_idle();
    chk("retain_floor", fl, 0);
    issue(6'b100000); repeat (3) @(negedge clk);   // fault while a call is pending
    try_fault(10); wait_idle();
    chk("fault_floor", fl, 5);

    fault_left = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      r = '0;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      req = r;
      if (fault_left > 0) begin
        fault_left--;
        if (fault_left == 0) flt_force = 1'b0;
      end else if ($urandom_range(0, 199) == 0 && !count_up && !count_down && !door_open) begin
        flt_force = 1'b1;
        fault_left = int'($urandom_range(3, 12));
      end
    end
    @(negedge clk);
    req = '0;
    flt_force = 1'b0;
    wait_idle();

    issue(6'b000001); wait_idle();                 // reset mid-step
    issue(6'b100000);
    n_cyc = 0;
    while (!count_up && n_cyc < 100) begin
      @(negedge clk);
      n_cyc++;
    end
    chk("count_up_seen", int'(count_up), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_count_up", int'(count_up), 0);
    chk("arst_door_open", int'(door_open), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_dir_up", int'(dir_up), 1);
    @(negedge clk);
    reset = 1'b0;
    issue(6'b000100); wait_idle();
    chk("post_rst_floor", fl, 2);
    chk("queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
